// File: rtl/alu_mul_sequencer.sv
// alu_mul_sequencer
//   Multi-cycle shift-add multiplier for the 24-bit single-cycle CPU. While
//   idle it passes the decoder's ALU control code and the datapath operands
//   straight to the shared ALU. On an accepted Start it takes over the ALU
//   add path and adds one partial product per cycle. Meanwhile it stalls the
//   core. It then presents the low WIDTH bits of the product for one
//   writeback cycle.
//
// Ports
//   Clock      in   system clock, rising edge
//   Resetn     in   asynchronous active-low reset
//   Start      in   multiply request (held high by the core while stalled)
//   OpA        in   multiplicand (rs)
//   OpB        in   multiplier (rt)
//   CtrlIn     in   ALU control code from decoder (pass-through source)
//   DpA, DpB   in   datapath ALU operands (pass-through source)
//   AluResult  in   shared ALU result
//   AluCtrl    out  control code to ALU
//   AluA, AluB out  ALU operands
//   Product    out  registered product, low WIDTH bits
//   Done       out  one-cycle pulse, Product valid for writeback
//   Busy       out  high while multiplying
//   Stall      out  freezes PC / register writes
module alu_mul_sequencer #(
  parameter int          WIDTH    = 24,
  parameter int          CNT_W    = 5,
  parameter logic [3:0]  ADD_CODE = 4'b0010
) (
  input  logic             Clock,
  input  logic             Resetn,
  input  logic             Start,
  input  logic [WIDTH-1:0] OpA,
  input  logic [WIDTH-1:0] OpB,
  input  logic [3:0]       CtrlIn,
  input  logic [WIDTH-1:0] DpA,
  input  logic [WIDTH-1:0] DpB,
  input  logic [WIDTH-1:0] AluResult,
  output logic [3:0]       AluCtrl,
  output logic [WIDTH-1:0] AluA,
  output logic [WIDTH-1:0] AluB,
  output logic [WIDTH-1:0] Product,
  output logic             Done,
  output logic             Busy,
  output logic             Stall
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] mcand;
  logic [WIDTH-1:0] mplier;
  logic [CNT_W-1:0] cnt;

  logic [WIDTH-1:0] acc_nxt;
  logic             last;

  // The ALU computes acc + mcand this cycle; keep it only when the current
  // multiplier bit is set.
  assign acc_nxt = mplier[0] ? AluResult : acc;

  // Stop as soon as no higher multiplier bits remain. This means the run
  // length tracks the highest set bit of OpB. The count bound is a backstop.
  assign last = (mplier[WIDTH-1:1] == '0) || (cnt == CNT_W'(WIDTH - 1));

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      state   <= ST_IDLE;
      acc     <= '0;
      mcand   <= '0;
      mplier  <= '0;
      cnt     <= '0;
      Product <= '0;
      Done    <= 1'b0;
      Busy    <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          Done <= 1'b0;
          if (Start) begin
            acc    <= '0;
            mcand  <= OpA;
            mplier <= OpB;
            cnt    <= '0;
            Busy   <= 1'b1;
            state  <= ST_RUN;
          end
        end
        ST_RUN: begin
          acc    <= acc_nxt;
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          cnt    <= cnt + CNT_W'(1);
          if (last) begin
            Product <= acc_nxt;
            Done    <= 1'b1;
            Busy    <= 1'b0;
            state   <= ST_DONE;
          end
        end
        ST_DONE: begin
          Done  <= 1'b0;
          state <= ST_IDLE;
        end
        default: begin
          Done  <= 1'b0;
          Busy  <= 1'b0;
          state <= ST_IDLE;
        end
      endcase
    end
  end

  // ALU input steering: the multiplier owns the ALU only while running.
  always_comb begin
    AluCtrl = CtrlIn;
    AluA    = DpA;
    AluB    = DpB;
    if (state == ST_RUN) begin
      AluCtrl = ADD_CODE;
      AluA    = acc;
      AluB    = mcand;
    end
  end

  // Stall covers the request cycle so the core freezes before RUN begins.
  // It is dropped in DONE so the writeback completes on that cycle. Gating
  // with Resetn keeps Stall low while reset is asserted, even if Start is high.
  assign Stall = Resetn &&
                 (((state == ST_IDLE) && Start) || (state == ST_RUN));

endmodule

// File: tb/tb_alu_mul_sequencer.sv
module tb_alu_mul_sequencer;

  localparam int         WIDTH = 24;
  localparam logic [3:0] ADD   = 4'b0010;

  logic             Clock = 1'b0;
  logic             Resetn;
  logic             Start;
  logic [WIDTH-1:0] OpA, OpB, DpA, DpB, AluResult;
  logic [3:0]       CtrlIn;
  logic [3:0]       AluCtrl;
  logic [WIDTH-1:0] AluA, AluB, Product;
  logic             Done, Busy, Stall;

  int n_cmp  = 0;
  int n_fail = 0;
  int done_seen = 0;
  int done_exp  = 0;
  logic [WIDTH-1:0] sb_q[$];

  always #5 Clock = ~Clock;

  // Shared ALU model: add for the add code, subtract otherwise.
  assign AluResult = (AluCtrl == ADD) ? (AluA + AluB) : (AluA - AluB);

  alu_mul_sequencer #(.WIDTH(WIDTH), .CNT_W(5), .ADD_CODE(ADD)) dut (
    .Clock(Clock), .Resetn(Resetn), .Start(Start), .OpA(OpA), .OpB(OpB),
    .CtrlIn(CtrlIn), .DpA(DpA), .DpB(DpB), .AluResult(AluResult),
    .AluCtrl(AluCtrl), .AluA(AluA), .AluB(AluB), .Product(Product),
    .Done(Done), .Busy(Busy), .Stall(Stall)
  );

  always @(negedge Clock) if (Resetn === 1'b1 && Done === 1'b1) done_seen++;

  task automatic check(input string tag, input logic [47:0] obs, input logic [47:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int exp_cycles(input logic [WIDTH-1:0] b);
    int n = 1;
    for (int i = 0; i < WIDTH; i++) if (b[i]) n = i + 1;
    return n;
  endfunction

  function automatic logic [WIDTH-1:0] model_mul(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    logic [2*WIDTH-1:0] p;
    p = {{WIDTH{1'b0}}, a} * {{WIDTH{1'b0}}, b};
    return p[WIDTH-1:0];
  endfunction

  // Called at a falling edge with the sequencer idle. Drives a request and
  // follows it through RUN and DONE. keep leaves Start high after DONE for a
  // back-to-back request. scramble alters the operands once RUN has begun.
  task automatic run_mul(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                         input bit keep, input bit scramble);
    int cyc;
    logic [WIDTH-1:0] exp_p;
    check("idle_done_low", Done, 0);
    OpA = a; OpB = b; Start = 1'b1;
    sb_q.push_back(model_mul(a, b));
    #1;
    check("stall_on_start", Stall, 1);
    check("busy_before_run", Busy, 0);
    @(negedge Clock);
    check("run_first_alua", AluA, 0);
    check("run_first_alub", AluB, a);
    if (scramble) begin
      OpA = $urandom; OpB = $urandom; DpA = $urandom; DpB = $urandom;
    end
    cyc = 0;
    while (Busy === 1'b1 && cyc < 40) begin
      if (AluCtrl !== ADD || Stall !== 1'b1)
        check("run_ctrl_stall", {AluCtrl, Stall}, {ADD, 1'b1});
      cyc++;
      @(negedge Clock);
    end
    check("run_cycles", cyc, exp_cycles(b));
    check("done_pulse", Done, 1);
    check("done_stall_low", Stall, 0);
    check("done_passthru", {AluCtrl, AluA, AluB}, {CtrlIn, DpA, DpB});
    done_exp++;
    if (sb_q.size() == 0) check("sb_empty", 1, 0);
    else begin
      exp_p = sb_q.pop_front();
      check("product", Product, exp_p);
    end
    if (!keep) Start = 1'b0;
    @(negedge Clock);
    check("done_one_cycle", Done, 0);
  endtask

  initial begin
    Resetn = 1'b0; Start = 1'b0; CtrlIn = 4'b1010;
    DpA = 24'd9; DpB = 24'd4; OpA = '0; OpB = '0;
    #12;
    check("rst_alu_passthru", {AluCtrl, AluA, AluB}, {4'b1010, 24'd9, 24'd4});
    check("rst_flags", {Stall, Busy, Done}, 3'b000);
    check("rst_product", Product, 0);
    @(negedge Clock); Resetn = 1'b1;
    @(negedge Clock);
    check("idle_passthru", {AluCtrl, AluA, AluB}, {4'b1010, 24'd9, 24'd4});
    check("idle_flags", {Stall, Busy, Done}, 3'b000);

    run_mul(24'd7, 24'd6, 1'b0, 1'b0);
    run_mul(24'hFFFFFF, 24'h800000, 1'b0, 1'b0);
    run_mul(24'd5, 24'd0, 1'b0, 1'b0);
    run_mul(24'd3, 24'd5, 1'b1, 1'b0);
    run_mul(24'd10, 24'd10, 1'b0, 1'b0);
    check("product_holds", Product, 100);

    // Reset in the middle of a run aborts it with no Done.
    OpA = 24'd100; OpB = 24'd200; Start = 1'b1;
    @(negedge Clock); @(negedge Clock); @(negedge Clock);
    check("abort_busy_pre", Busy, 1);
    Resetn = 1'b0;
    #1;
    check("abort_flags", {Stall, Busy, Done}, 3'b000);
    check("abort_product", Product, 0);
    check("abort_passthru", {AluCtrl, AluA, AluB}, {CtrlIn, DpA, DpB});
    Start = 1'b0;
    @(negedge Clock); Resetn = 1'b1;
    repeat (12) @(negedge Clock);
    check("abort_no_done", done_seen, done_exp);
    run_mul(24'd12, 24'd12, 1'b0, 1'b0);

    run_mul(24'd11, 24'd13, 1'b0, 1'b1);
    repeat (2) @(negedge Clock);
    check("done_count", done_seen, done_exp);
    check("sb_drained", sb_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_mul_sequencer.md
Name: alu_mul_sequencer

Overview:
Multi-cycle shift-add multiplier sequencer for the 24-bit single-cycle CPU. It borrows the shared ALU's add path, one partial product per cycle, and stalls the core while it runs. When idle, it passes the datapath's ALU control code and operands straight through to the ALU, so normal single-cycle instructions are unaffected. It sits between the ALU control decoder/datapath and the ALU inputs.

Parameters:
WIDTH, 24, operand/result width in bits
CNT_W, 5, iteration counter width (must satisfy 2^CNT_W >= WIDTH)
ADD_CODE, 4'b0010, ALU control code driven during accumulation (ALU add)

Ports:
Clock  input  1  system clock, rising edge
Resetn  input  1  asynchronous active-low reset
Start  input  1  multiply request from main control; held high by core while stalled
OpA  input  WIDTH  multiplicand (rs value)
OpB  input  WIDTH  multiplier (rt value)
CtrlIn  input  4  ALU control code from decoder (pass-through source)
DpA  input  WIDTH  datapath ALU operand A (pass-through source)
DpB  input  WIDTH  datapath ALU operand B (pass-through source)
AluResult  input  WIDTH  shared ALU result
AluCtrl  output  4  control code to ALU
AluA  output  WIDTH  ALU operand A
AluB  output  WIDTH  ALU operand B
Product  output  WIDTH  registered product, low WIDTH bits
Done  output  1  one-cycle pulse: Product valid for writeback
Busy  output  1  high while state is RUN
Stall  output  1  freezes PC/register writes

Behaviour:
- Clock and reset: one clock (Clock); reset (Resetn) is asynchronous and active-low.
- Reset, asynchronous, Resetn=0: state is IDLE; acc, mcand, mplier, cnt and Product are 0; Done=0; Busy=0; Stall is forced to 0. Reset during RUN aborts the operation with no Done.
- States: IDLE, RUN, DONE.
- IDLE:
  - Outputs: AluCtrl=CtrlIn, AluA=DpA, AluB=DpB (combinational pass-through).
  - Start=1 at the clock edge: acc<=0, mcand<=OpA, mplier<=OpB, cnt<=0, next state RUN.
- RUN:
  - Outputs: AluCtrl=ADD_CODE, AluA=acc, AluB=mcand.
  - Each edge: if mplier[0]=1, acc<=AluResult; otherwise acc holds. Then mcand<=mcand<<1, mplier<=mplier>>1, cnt<=cnt+1.
  - Exit to DONE when (mplier>>1)==0 or cnt==WIDTH-1. Product<=final acc value, including this cycle's add.
  - RUN cycles = (index of highest set bit of OpB)+1. Minimum 1 (OpB=0 gives 1 cycle, Product 0). Maximum WIDTH.
- DONE:
  - Done=1 for exactly one cycle; pass-through is restored; next state IDLE.
  - Product holds until the next accepted Start or reset.
- Stall = (IDLE & Start) | RUN. It is low in DONE, so the core writes back Product and advances at the end of the DONE cycle.
- Start is ignored in RUN and DONE; operands are not re-sampled. Start high in the IDLE cycle after DONE (back-to-back multiply) is accepted normally.
- Arithmetic: the result is modulo 2^WIDTH. Low bits are identical for signed and unsigned two's-complement operands. Overflow is discarded; there is no flag.
- OpA/OpB/DpA/DpB changes during RUN have no effect.

Test Plan:
- Reset then idle, Start=0, CtrlIn=4'b1010, DpA=9, DpB=4 -> AluCtrl=4'b1010, AluA=9, AluB=4; Stall=0, Busy=0, Done=0, Product=0.
- OpA=7, OpB=6, Start pulse held -> Stall high from the Start cycle; 3 RUN cycles with AluCtrl=4'b0010; Done for 1 cycle; Product=42; Stall low during Done.
- OpA=24'hFFFFFF (-1), OpB=24'h800000 -> 24 RUN cycles, Product=24'h800000. Also OpA=5, OpB=0 -> 1 RUN cycle, Product=0.
- Back-to-back: 3*5, Start remains high the cycle after Done with new operands 10*10 -> Product=15, then Product=100; two Done pulses.
- Resetn low mid-RUN of 100*200 -> immediate IDLE, Product=0, Stall=0, no Done. After release, 12*12 -> Product=144.
- Operand change mid-RUN, OpA/OpB altered after acceptance of 11*13 -> Product=143.
